// File: rtl/fsk_demod_pkg.sv
// Shared types and constants for the FSK demodulator front-end sequencer.
// Holds the sequencer state encoding, the mode codes and the per-mode symbol mask.
package fsk_demod_pkg;

  localparam int unsigned SymW = 4;
  localparam int unsigned AdcW = 18;

  typedef enum logic [1:0] {
    StSearch,
    StAcq,
    StCorr,
    StEmit
  } state_e;

  localparam logic [1:0] Mode16 = 2'd0;
  localparam logic [1:0] Mode8  = 2'd1;
  localparam logic [1:0] Mode4  = 2'd2;
  localparam logic [1:0] Mode2  = 2'd3;

  // Bits of the correlator index that carry information in each M-FSK mode.
  function automatic logic [SymW-1:0] mode_mask(input logic [1:0] mode);
    logic [SymW-1:0] m;
    m = '0;
    unique case (mode)
      Mode16: m = 4'hF;
      Mode8:  m = 4'h7;
      Mode4:  m = 4'h3;
      Mode2:  m = 4'h1;
      default: m = 4'hF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fsk_sync_detector.sv
// Run-length sync detector: pulses sync_hit on the sample that completes a run of
// SYNC_COUNT_REQUIRED consecutive samples strictly above SYNC_THRESHOLD.
module fsk_sync_detector
  import fsk_demod_pkg::*;
#(
  parameter int          SYNC_THRESHOLD      = 1,
  parameter int unsigned SYNC_COUNT_REQUIRED = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            active,
  input  logic [AdcW-1:0] adc_in_sin,
  output logic            sync_hit
);

  localparam int unsigned RunW = $clog2(SYNC_COUNT_REQUIRED + 1);
  localparam logic signed [AdcW-1:0] Thr = AdcW'(SYNC_THRESHOLD);

  logic [RunW-1:0] run_q, run_d;
  logic            high;

  assign high     = $signed(adc_in_sin) > Thr;
  assign sync_hit = active && high && (run_q == RunW'(SYNC_COUNT_REQUIRED - 1));

  // The run restarts after a hit so a long sync burst cannot re-trigger immediately.
  always_comb begin
    run_d = '0;
    if (active && high && !sync_hit) begin
      run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/fsk_demod_sequencer.sv
// Front-end controller for the FSK correlator: finds sync, frames symbol windows,
// drives sample writes and correlation, and hands decisions out on a valid/ready port.
module fsk_demod_sequencer
  import fsk_demod_pkg::*;
#(
  parameter int unsigned N                   = 99,
  parameter int unsigned IDX_W               = 7,
  parameter int          SYNC_THRESHOLD      = 1,
  parameter int unsigned SYNC_COUNT_REQUIRED = 8,
  parameter int unsigned SYMS_PER_FRAME      = 16,
  parameter int unsigned CORR_TIMEOUT        = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [AdcW-1:0]  adc_in_sin,
  output logic             sample_en,
  output logic [IDX_W-1:0] sample_idx,
  output logic             corr_start,
  input  logic             corr_done,
  input  logic [SymW-1:0]  corr_symbol,
  input  logic             corr_energy_ok,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [SymW-1:0]  sym_data,
  output logic             sym_erasure,
  output logic             frame_active,
  output logic             frame_done,
  output logic             err_timeout,
  output logic             err_overflow
);

  localparam int unsigned WaitW = $clog2(CORR_TIMEOUT);
  localparam int unsigned CntW  = $clog2(SYMS_PER_FRAME + 1);

  state_e          state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [SymW-1:0]  last_good_q, last_good_d;
  logic [SymW-1:0]  cap_sym_q, cap_sym_d;
  logic             cap_ok_q, cap_ok_d;
  logic             out_valid_q, out_valid_d;
  logic [SymW-1:0]  out_data_q, out_data_d;
  logic             out_era_q, out_era_d;
  logic             frame_done_q, frame_done_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_overflow_q, err_overflow_d;
  logic             sync_hit;
  logic [SymW-1:0]  emit_sym;

  fsk_sync_detector #(
    .SYNC_THRESHOLD      (SYNC_THRESHOLD),
    .SYNC_COUNT_REQUIRED (SYNC_COUNT_REQUIRED)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .active     (enable && (state_q == StSearch)),
    .adc_in_sin (adc_in_sin),
    .sync_hit   (sync_hit)
  );

  // Low-energy decisions repeat the last good symbol and are flagged as erasures.
  assign emit_sym = cap_ok_q ? (cap_sym_q & mode_mask(mode_q)) : last_good_q;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wait_d         = wait_q;
    cnt_d          = cnt_q;
    mode_d         = mode_q;
    last_good_d    = last_good_q;
    cap_sym_d      = cap_sym_q;
    cap_ok_d       = cap_ok_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_era_d      = out_era_q;
    frame_done_d   = 1'b0;
    err_timeout_d  = err_timeout_q;
    err_overflow_d = err_overflow_q;

    if (out_valid_q && sym_ready) begin
      out_valid_d = 1'b0;
    end

    if (!enable) begin
      state_d = StSearch;
      idx_d   = '0;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        StSearch: begin
          if (sync_hit) begin
            mode_d  = mode;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = StAcq;
          end
        end
        StAcq: begin
          if (idx_q == IDX_W'(N - 1)) begin
            idx_d   = '0;
            wait_d  = '0;
            state_d = StCorr;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        StCorr: begin
          if (corr_done) begin
            cap_sym_d = corr_symbol;
            cap_ok_d  = corr_energy_ok;
            wait_d    = '0;
            state_d   = StEmit;
          end else if (wait_q == WaitW'(CORR_TIMEOUT - 1)) begin
            err_timeout_d = 1'b1;
            wait_d        = '0;
            state_d       = StSearch;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        StEmit: begin
          if (cap_ok_q) begin
            last_good_d = emit_sym;
          end
          if (!out_valid_q || sym_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = emit_sym;
            out_era_d   = !cap_ok_q;
          end else begin
            err_overflow_d = 1'b1;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(SYMS_PER_FRAME - 1)) begin
            frame_done_d = 1'b1;
            state_d      = StSearch;
          end else begin
            state_d = StAcq;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StSearch;
      idx_q          <= '0;
      wait_q         <= '0;
      cnt_q          <= '0;
      mode_q         <= '0;
      last_good_q    <= '0;
      cap_sym_q      <= '0;
      cap_ok_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_era_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      wait_q         <= wait_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      last_good_q    <= last_good_d;
      cap_sym_q      <= cap_sym_d;
      cap_ok_q       <= cap_ok_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_era_q      <= out_era_d;
      frame_done_q   <= frame_done_d;
      err_timeout_q  <= err_timeout_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign sample_en    = enable && (state_q == StAcq);
  assign sample_idx   = idx_q;
  assign corr_start   = enable && (state_q == StCorr) && (wait_q == '0);
  assign frame_active = state_q != StSearch;
  assign frame_done   = frame_done_q;
  assign sym_valid    = out_valid_q;
  assign sym_data     = out_data_q;
  assign sym_erasure  = out_era_q;
  assign err_timeout  = err_timeout_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_fsk_demod_sequencer.sv
// Directed-plus-random bench for fsk_demod_sequencer with a transaction-level symbol model.
module tb_fsk_demod_sequencer;

  localparam int unsigned N   = 99;
  localparam int unsigned SPF = 16;
  localparam int unsigned TMO = 1024;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [17:0] adc_in_sin;
  logic        sample_en;
  logic [6:0]  sample_idx;
  logic        corr_start;
  logic        corr_done;
  logic [3:0]  corr_symbol;
  logic        corr_energy_ok;
  logic        sym_valid;
  logic        sym_ready;
  logic [3:0]  sym_data;
  logic        sym_erasure;
  logic        frame_active;
  logic        frame_done;
  logic        err_timeout;
  logic        err_overflow;

  int checks   = 0;
  int failures = 0;
  int bad;

  // Reference model: held mode, last good symbol, output slot and sticky flags.
  logic [1:0] m_mode;
  logic [3:0] m_last_good;
  logic [3:0] m_data;
  logic       m_era;
  logic       m_pend;
  logic       m_ovf;
  logic       m_tmo;
  int         m_cnt;

  fsk_demod_sequencer #(
    .N                   (N),
    .IDX_W               (7),
    .SYNC_THRESHOLD      (1),
    .SYNC_COUNT_REQUIRED (8),
    .SYMS_PER_FRAME      (SPF),
    .CORR_TIMEOUT        (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mode           (mode),
    .adc_in_sin     (adc_in_sin),
    .sample_en      (sample_en),
    .sample_idx     (sample_idx),
    .corr_start     (corr_start),
    .corr_done      (corr_done),
    .corr_symbol    (corr_symbol),
    .corr_energy_ok (corr_energy_ok),
    .sym_valid      (sym_valid),
    .sym_ready      (sym_ready),
    .sym_data       (sym_data),
    .sym_erasure    (sym_erasure),
    .frame_active   (frame_active),
    .frame_done     (frame_done),
    .err_timeout    (err_timeout),
    .err_overflow   (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] adc_high();
    int v;
    v = int'($urandom_range(131071, 2));
    return 18'(v);
  endfunction

  function automatic logic [17:0] adc_low();
    int v;
    v = 1 - int'($urandom_range(131073, 0));
    return 18'(v);
  endfunction

  // One clock; the model drains its output slot on an accepted handshake.
  task automatic step();
    logic drain;
    drain = m_pend && sym_ready;
    @(negedge clk);
    if (drain) m_pend = 1'b0;
  endtask

  task automatic check_port();
    check("sym_valid", sym_valid, m_pend);
    if (m_pend) begin
      check("sym_data", sym_data, m_data);
      check("sym_erasure", sym_erasure, m_era);
    end
    check("err_overflow", err_overflow, m_ovf);
    check("err_timeout", err_timeout, m_tmo);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {sample_en, sample_idx, corr_start, sym_valid, sym_data, sym_erasure,
                frame_active, frame_done, err_timeout, err_overflow}, 32'd0);
  endtask

  task automatic do_sync(input logic [1:0] md);
    int b = 0;
    mode = md;
    for (int i = 0; i < 8; i++) begin
      if (sample_en !== 1'b0) b++;
      adc_in_sin = adc_high();
      step();
    end
    adc_in_sin = adc_low();
    check("sync_no_early", b, 0);
    check("sync_sample_en", sample_en, 1'b1);
    check("sync_frame_active", frame_active, 1'b1);
    m_mode = md;
    m_cnt  = 0;
  endtask

  task automatic do_acq();
    int b = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (sample_en !== 1'b1 || sample_idx !== 7'(i) || corr_start !== 1'b0) b++;
      if (i == 50) corr_done = 1'b1;  // stray pulse outside CORR must be ignored
      step();
      corr_done = 1'b0;
    end
    check("acq_window", b, 0);
    check("corr_start", corr_start, 1'b1);
    check("corr_no_sample", sample_en, 1'b0);
    check_port();
  endtask

  task automatic do_emit(input logic [3:0] sym, input logic ok, input int delay);
    int b = 0;
    int mask;
    logic accept;
    logic last;
    logic [3:0] exp_sym;
    for (int i = 0; i < delay; i++) begin
      step();
      if (corr_start !== 1'b0 || frame_active !== 1'b1) b++;
    end
    check("corr_wait", b, 0);
    corr_done      = 1'b1;
    corr_symbol    = sym;
    corr_energy_ok = ok;
    step();
    corr_done = 1'b0;
    check("emit_no_sample", sample_en, 1'b0);
    accept = !m_pend || sym_ready;
    step();
    mask = (1 << (4 - int'(m_mode))) - 1;
    if (ok) begin
      exp_sym     = 4'(int'(sym) & mask);
      m_last_good = exp_sym;
    end else begin
      exp_sym = m_last_good;
    end
    if (accept) begin
      m_pend = 1'b1;
      m_data = exp_sym;
      m_era  = !ok;
    end else begin
      m_ovf = 1'b1;
    end
    m_cnt++;
    last = (m_cnt == int'(SPF));
    check_port();
    check("frame_done", frame_done, last);
    check("frame_active", frame_active, !last);
    check("next_acq", sample_en, !last);
    if (last) m_cnt = 0;
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    mode           = 2'd0;
    adc_in_sin     = adc_high();
    corr_done      = 1'b0;
    corr_symbol    = 4'd0;
    corr_energy_ok = 1'b0;
    sym_ready      = 1'b1;
    m_mode = 2'd0; m_last_good = 4'd0; m_data = 4'd0; m_era = 1'b0;
    m_pend = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0; m_cnt = 0;
    repeat (3) step();
    check_all_zero("reset_outputs");
    reset      = 1'b0;
    adc_in_sin = adc_low();
    step();

    // Seven highs, a sample equal to the threshold, then exactly eight highs.
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      adc_in_sin = adc_high();
      step();
      if (sample_en !== 1'b0) bad++;
    end
    adc_in_sin = 18'd1;
    step();
    if (sample_en !== 1'b0) bad++;
    for (int i = 0; i < 7; i++) begin
      adc_in_sin = (i == 0) ? 18'd2 : adc_high();
      step();
      if (sample_en !== 1'b0 || frame_active !== 1'b0) bad++;
    end
    check("no_early_sync", bad, 0);
    adc_in_sin = adc_high();
    step();
    adc_in_sin = adc_low();
    check("sync_sample_en", sample_en, 1'b1);
    check("sync_idx0", sample_idx, 7'd0);
    check("sync_frame_active", frame_active, 1'b1);
    m_mode = 2'd0;
    m_cnt  = 0;

    // Frame 1 in 16-FSK; a mid-frame mode change must not alter masking.
    do_acq();
    do_emit(4'd9, 1'b1, 0);
    mode = 2'd2;
    do_acq();
    do_emit(4'hF, 1'b1, 3);
    for (int w = 2; w < int'(SPF); w++) begin
      do_acq();
      do_emit(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(6, 0)));
    end
    step();
    check("frame_done_pulse", frame_done, 1'b0);
    check("idle_after_frame", sample_en, 1'b0);
    repeat (3) step();

    // Frame 2 in 4-FSK: masking, erasure, then overflow with the consumer stalled.
    do_sync(2'd2);
    do_acq();
    do_emit(4'hB, 1'b1, 1);
    check("mask_4fsk", sym_data, 4'd3);
    do_acq();
    do_emit(4'($urandom_range(15, 0)), 1'b0, 2);
    check("erasure_repeat", {sym_erasure, sym_data}, 5'h13);
    sym_ready = 1'b0;
    do_acq();
    do_emit(4'($urandom_range(15, 0)), 1'b1, 0);
    do_acq();
    do_emit(4'($urandom_range(15, 0)), 1'b1, 4);
    check("overflow_set", err_overflow, 1'b1);
    sym_ready = 1'b1;
    do_acq();
    check("drain_valid", sym_valid, 1'b0);
    check("overflow_sticky", err_overflow, 1'b1);

    // Correlator never answers: timeout on the 1024th CORR cycle.
    bad = 0;
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      step();
      if (frame_active !== 1'b1 || err_timeout !== 1'b0 || corr_start !== 1'b0) bad++;
    end
    check("tmo_wait", bad, 0);
    step();
    check("tmo_flag", err_timeout, 1'b1);
    check("tmo_search", frame_active, 1'b0);
    check("tmo_no_done", frame_done, 1'b0);
    m_tmo = 1'b1;
    repeat (4) step();
    check("tmo_idle", sample_en, 1'b0);
    check_port();

    // Disabled: a valid sync burst must be ignored.
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      adc_in_sin = adc_high();
      step();
      if (sample_en !== 1'b0 || frame_active !== 1'b0) bad++;
    end
    check("disabled_no_sync", bad, 0);
    enable     = 1'b1;
    adc_in_sin = adc_low();
    step();

    // Frame 3 in 2-FSK, then reset in the middle of a window with a symbol pending.
    do_sync(2'd3);
    do_acq();
    do_emit(4'($urandom_range(15, 0)), 1'b1, 2);
    sym_ready = 1'b0;
    do_acq();
    do_emit(4'($urandom_range(15, 0)), 1'b1, 0);
    repeat (40) step();
    check("pre_reset_pending", sym_valid, 1'b1);
    reset = 1'b1;
    step();
    check_all_zero("reset_mid_acq");
    reset = 1'b0;
    m_pend = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0; m_last_good = 4'd0; m_cnt = 0;
    step();
    check("post_reset_idle", sample_en, 1'b0);
    check_port();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
